chronologic: RTL and testbench
==============================

Name: chronologic

Overview:
- One-cycle x-to-y follower with a built-in protocol checker.
- Generates `y_sig` as `x_sig` registered by one clock.
- Independently checks an externally observed y signal against the rule "x high implies y high one cycle later". Pass, fail and attempt counts are kept for coverage and status readback.
- Sits beside any single-bit request/acknowledge path that must answer on the next clock.

Parameters:
- CNT_W, 16, width of the attempt, pass and fail counters.
- STICKY_ERR, 1, 1 = `err_sticky` holds until `clr`; 0 = `err_sticky` mirrors `err_pulse`.

Ports:
- clk  in  1  single system clock, rising-edge active.
- rst_n  in  1  asynchronous, active-HIGH reset. Despite the name, rst_n=1 holds the block in reset; the checker is disabled while it is high.
- x_sig  in  1  trigger signal.
- y_obs  in  1  observed response signal under check.
- clr  in  1  synchronous clear of counters and sticky error.
- y_sig  out  1  x_sig delayed by exactly one clock.
- pend  out  1  a check is armed for the next edge.
- err_pulse  out  1  one-cycle pulse on a failed check.
- err_sticky  out  1  latched failure flag.
- attempt_cnt  out  CNT_W  number of evaluated clock edges.
- pass_cnt  out  CNT_W  number of successful checks.
- fail_cnt  out  CNT_W  number of failed checks.

Behaviour:
- Reset (rst_n=1, asynchronous assert; deassert is sampled at the next clk edge):
  - y_sig, pend, err_pulse and err_sticky are 0; all counters are 0.
  - Any armed check is discarded and is counted as neither pass nor fail.
- Follower: at each rising edge out of reset, y_sig <= x_sig. Latency is exactly 1 cycle; there is no combinational path from x_sig to y_sig.
- Attempts: each rising edge out of reset increments attempt_cnt by 1, whether or not x_sig is high.
- Arming: at an edge with x_sig=1, pend <= 1. At an edge with x_sig=0, pend <= 0.
- Checking: at an edge where pend=1 (armed on the previous edge), evaluate y_obs:
  - y_obs=1: pass_cnt increments.
  - y_obs=0: fail_cnt increments, err_pulse <= 1 for that cycle, err_sticky <= 1.
  - At an edge where pend=0, err_pulse <= 0.
- Overlap: when x_sig stays high on consecutive edges, each edge arms a new check while the previous one is resolved on the same edge. The checks are independent, so N consecutive high samples yield N checks.
- Simultaneous clr and check: the clr clears counters and err_sticky first, then the current check result is applied. Example: clr plus a failing check gives fail_cnt=1, err_sticky=1.
- clr does not affect y_sig or pend.
- Saturation: all counters saturate at all-ones and never wrap.
- STICKY_ERR=0: err_sticky equals err_pulse.
- Reset mid-check: reset asserted while pend=1 drops the check. After release, checking resumes from a clean state on the first sampled edge.
- y_obs is checked only in the cycle after x_sig=1. y_obs activity at any other time is ignored, as is y_obs=1 when x was 0.

Test Plan:
- Reset then release, x_sig=0 for 5 edges -> y_sig=0, attempt_cnt=5, pass_cnt=0, fail_cnt=0, err_sticky=0.
- x_sig=1 for one edge, y_obs=1 at the next edge -> y_sig=1 one cycle after x, pass_cnt=1, no err_pulse.
- x_sig=1 for one edge, y_obs=0 at the next edge -> err_pulse high for exactly 1 cycle, fail_cnt=1, err_sticky=1 until clr; after clr, fail_cnt=0 and err_sticky=0.
- x_sig=1 for 3 consecutive edges, y_obs=1,0,1 on the following 3 edges -> pass_cnt=2, fail_cnt=1.
- x_sig=1 at edge k, rst_n raised before edge k+1, y_obs=0 -> no fail counted, all outputs 0 during reset, and attempt_cnt does not advance while rst_n=1.
- Force counters near max with CNT_W=4 and 20 failing checks -> fail_cnt holds at 15 with no wrap.

Source files
------------

// File: rtl/chronologic.sv
// chronologic: one-cycle x->y follower plus a checker that y_obs answers x on the next edge,
// with saturating attempt/pass/fail counters and an error pulse and latch.
module chronologic #(
  parameter int CNT_W      = 16,
  parameter bit STICKY_ERR = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             x_sig,
  input  logic             y_obs,
  input  logic             clr,
  output logic             y_sig,
  output logic             pend,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [CNT_W-1:0] attempt_cnt,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt
);
  logic chk_pass, chk_fail;
  assign chk_pass = pend & y_obs;
  assign chk_fail = pend & ~y_obs;
  // clr zeroes the count first, so a same-edge event still lands on top of it
  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c, input logic en, input logic clear);
    logic [CNT_W-1:0] b;
    b = clear ? '0 : c;
    return (en && b != '1) ? b + CNT_W'(1) : b;
  endfunction
  always_ff @(posedge clk or posedge rst_n)
    if (rst_n) begin
      y_sig       <= 1'b0;
      pend        <= 1'b0;
      err_pulse   <= 1'b0;
      err_sticky  <= 1'b0;
      attempt_cnt <= '0;
      pass_cnt    <= '0;
      fail_cnt    <= '0;
    end else begin
      y_sig       <= x_sig;
      pend        <= x_sig;
      err_pulse   <= chk_fail;
      err_sticky  <= STICKY_ERR ? (~clr & err_sticky) | chk_fail : chk_fail;
      attempt_cnt <= bump(attempt_cnt, 1'b1, clr);
      pass_cnt    <= bump(pass_cnt, chk_pass, clr);
      fail_cnt    <= bump(fail_cnt, chk_fail, clr);
    end
endmodule

// File: tb/tb_chronologic.sv
// tb_chronologic: randomized and directed stimulus against three chronologic builds, checked by a
// queue-based scoreboard fed from an event-count reference model.
module tb_chronologic;
  logic clk = 1'b0;
  logic rst_n = 1'b1, x_sig = 1'b0, y_obs = 1'b0, clr = 1'b0;
  always #5 clk = ~clk;

  logic        ys_a, pd_a, ep_a, es_a;
  logic [15:0] at_a, ps_a, fl_a;
  logic        ys_b, pd_b, ep_b, es_b;
  logic [3:0]  at_b, ps_b, fl_b;
  logic        ys_c, pd_c, ep_c, es_c;
  logic [15:0] at_c, ps_c, fl_c;

  chronologic #(.CNT_W(16), .STICKY_ERR(1)) dut_a (.clk(clk), .rst_n(rst_n), .x_sig(x_sig), .y_obs(y_obs), .clr(clr),
    .y_sig(ys_a), .pend(pd_a), .err_pulse(ep_a), .err_sticky(es_a), .attempt_cnt(at_a), .pass_cnt(ps_a), .fail_cnt(fl_a));
  chronologic #(.CNT_W(4), .STICKY_ERR(1)) dut_b (.clk(clk), .rst_n(rst_n), .x_sig(x_sig), .y_obs(y_obs), .clr(clr),
    .y_sig(ys_b), .pend(pd_b), .err_pulse(ep_b), .err_sticky(es_b), .attempt_cnt(at_b), .pass_cnt(ps_b), .fail_cnt(fl_b));
  chronologic #(.CNT_W(16), .STICKY_ERR(0)) dut_c (.clk(clk), .rst_n(rst_n), .x_sig(x_sig), .y_obs(y_obs), .clr(clr),
    .y_sig(ys_c), .pend(pd_c), .err_pulse(ep_c), .err_sticky(es_c), .attempt_cnt(at_c), .pass_cnt(ps_c), .fail_cnt(fl_c));

  typedef struct {
    logic ys, pd, ep, es;
    int   a, p, f;
  } exp_t;
  exp_t q[$];
  int vectors = 0, miscompares = 0;

  // reference model: true event counts since the last clr/reset; width limits applied on compare
  logic m_pend = 1'b0, m_es = 1'b0;
  int   m_a = 0, m_p = 0, m_f = 0;

  function automatic int sat(input int v, input int w);
    return v > (1 << w) - 1 ? (1 << w) - 1 : v;
  endfunction

  task automatic chk(input string n, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask

  task automatic step(input logic x, input logic y, input logic c, input logic r);
    exp_t e;
    @(negedge clk);
    x_sig = x; y_obs = y; clr = c; rst_n = r;
    if (r) begin
      m_pend = 0; m_es = 0; m_a = 0; m_p = 0; m_f = 0;
      e = '{ys: 0, pd: 0, ep: 0, es: 0, a: 0, p: 0, f: 0};
    end else begin
      if (c) begin m_a = 0; m_p = 0; m_f = 0; m_es = 0; end
      m_a++;
      e.ep = m_pend && !y;
      if (m_pend) begin
        if (y) m_p++;
        else begin m_f++; m_es = 1; end
      end
      m_pend = x;
      e.ys = x; e.pd = x; e.es = m_es; e.a = m_a; e.p = m_p; e.f = m_f;
    end
    q.push_back(e);
  endtask

  // monitor: one expected response per clock edge, sampled 1 time unit after the edge
  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("a.y_sig", ys_a, e.ys);           chk("a.pend", pd_a, e.pd);
      chk("a.err_pulse", ep_a, e.ep);       chk("a.err_sticky", es_a, e.es);
      chk("a.attempt", at_a, sat(e.a, 16)); chk("a.pass", ps_a, sat(e.p, 16)); chk("a.fail", fl_a, sat(e.f, 16));
      chk("b.y_sig", ys_b, e.ys);           chk("b.pend", pd_b, e.pd);
      chk("b.err_pulse", ep_b, e.ep);       chk("b.err_sticky", es_b, e.es);
      chk("b.attempt", at_b, sat(e.a, 4));  chk("b.pass", ps_b, sat(e.p, 4));   chk("b.fail", fl_b, sat(e.f, 4));
      chk("c.y_sig", ys_c, e.ys);           chk("c.pend", pd_c, e.pd);
      chk("c.err_pulse", ep_c, e.ep);       chk("c.err_sticky", es_c, e.ep);
      chk("c.attempt", at_c, sat(e.a, 16)); chk("c.pass", ps_c, sat(e.p, 16)); chk("c.fail", fl_c, sat(e.f, 16));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    #2;
    chk("reset.async_y_sig", ys_a, 0);
    chk("reset.async_fail", fl_a, 0);
    repeat (2) step(0, 0, 0, 1);
    repeat (5) step(0, 0, 0, 0);
    step(1, 0, 0, 0); step(0, 1, 0, 0); step(0, 0, 0, 0);
    step(1, 0, 0, 0); step(0, 0, 0, 0); repeat (3) step(0, 1, 0, 0);
    step(0, 0, 1, 0); step(0, 0, 0, 0);
    step(1, 0, 0, 0); step(1, 1, 0, 0); step(1, 0, 0, 0); step(0, 1, 0, 0); step(0, 0, 0, 0);
    step(1, 0, 0, 0); step(0, 0, 0, 1); step(0, 0, 0, 1); step(0, 0, 0, 0); step(0, 0, 0, 0);
    step(1, 0, 0, 0); step(0, 0, 1, 0); step(0, 0, 0, 0);
    repeat (20) step(1, 0, 0, 0);
    step(0, 0, 0, 0); step(0, 1, 1, 0);
    repeat (400) step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 15) == 0, $urandom_range(0, 39) == 0);
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard.drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
